int_sched: RTL and testbench
============================

# int_sched

Interrupt scheduler for the 8051 core. Sits between the SFR block (IE, IP, TCON mode bits, flag sources) and the CPU. Per machine cycle it samples the five interrupt flags, resolves priority and nesting, presents one vector to the CPU, and on acceptance pulses the hardware flag-clear and tracks in-service levels until RETI.

## Interface
- No parameters; vector table and source order are fixed constants.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- tick  in  1  one-clk strobe, once per machine cycle (sample point)
- ie  in  8  IE SFR; bit7 EA, bits4:0 ES, ET1, EX1, ET0, EX0
- ip  in  8  IP SFR; bits4:0 per-source priority (1 = high)
- flags  in  5  {serial(RI|TI), TF1, IE1, TF0, IE0}, bit0 = IE0
- it_mode  in  2  {IT1, IT0}; 1 = edge-triggered external interrupt
- block  in  1  CPU executing RETI or writing IE/IP this cycle
- ack  in  1  CPU accepts request (starts hardware LCALL)
- reti  in  1  one-clk pulse, CPU completed RETI
- int_req  out  1  request to CPU; reset 0
- vector  out  16  target address; reset 16'h0000
- src_id  out  3  winning source 0-4; reset 0
- clr_flag  out  5  one-clk flag-clear pulses, same bit order as flags; reset 0
- in_svc_hi  out  1  high-level interrupt in service; reset 0
- in_svc_lo  out  1  low-level interrupt in service; reset 0

## Operation
- States: IDLE, POLL, REQ. Reset -> IDLE, all outputs at reset values.
- IDLE: on tick, latch pend = flags & ie[4:0] & {5{ie[7]}}; go POLL if pend != 0, else stay.
- POLL (one clk): winner = lowest index among high-priority pending; if none, lowest index among low-priority pending. Fixed order IE0 > TF0 > IE1 > TF1 > serial. Eligible only if block=0, in_svc_hi=0, and (winner high, or in_svc_lo=0). Eligible -> REQ with src_id/vector loaded; else -> IDLE (retried next tick).
- Vectors: 0x0003, 0x000B, 0x0013, 0x001B, 0x0023 for src 0..4.
- REQ: int_req=1, vector/src_id stable. Each cycle re-check ie[7] and ie bit of src_id; if either cleared, withdraw: int_req=0, -> IDLE. ack=1 -> IDLE, set in_svc of winner level, emit clr_flag.
- clr_flag: TF0/TF1 always pulsed on acceptance; IE0/IE1 pulsed only if matching it_mode bit is 1; serial never pulsed.
- reti: clears in_svc_hi if set, else in_svc_lo. reti with neither set: ignored.
- ack outside REQ: ignored.

## Timing
- tick at cycle t -> POLL at t+1 -> int_req at t+2 earliest.
- ack at cycle a -> int_req=0 and clr_flag pulse at a+1, in_svc set at a+1.
- reti and ack same cycle: reti clears first, then ack sets (net: level of new source set).
- tick in POLL/REQ: ignored; no resampling while a request is outstanding.
- block sampled only in POLL; block during REQ has no effect.
- reset mid-REQ: int_req drops next clk, in-service state lost.

## Configuration
- INT_SCHED_PRIORITY_EN defined: two levels as above; ip honoured; high may preempt low in service.
- Undefined: ip ignored, all sources low; in_svc_hi stays 0; any in-service interrupt blocks all others.

## Structure
- Shared package: state encoding, source indices, vector constants (VEC_IE0..VEC_SER), flag bit positions.
- One sub-module natural: int_prio_enc (combinational winner select from pend and ip; outputs valid, index, level).

## Test plan
- EA=1, EX0=1, IT0=1, IE0 set, tick -> int_req 2 clks later, vector 0x0003; ack -> clr_flag=5'b00001, in_svc_lo=1.
- IE0 and TF1 pending, IP.TF1=1 -> vector 0x001B, src_id 3; IE0 served after reti.
- Low serial in service, high TF0 raised -> preempt with vector 0x000B, in_svc_hi=1; first reti clears hi only.
- Request pending in REQ, CPU writes ie[7]=0 -> int_req drops next clk, no clr_flag, no in_svc change.
- block=1 in POLL -> no request; next tick with block=0 -> request issued; IT1=0 on IE1 acceptance -> clr_flag=0.
- Reset asserted during REQ with in_svc_lo=1 -> next clk all outputs reset values, state IDLE.

Source files
------------

// File: rtl/int_sched_pkg.sv
// rtl/int_sched_pkg.sv - shared constants for the 8051 interrupt scheduler
// Purpose: scheduler state encoding, source indices, flag bit positions,
//          vector table and the acceptance flag-clear rule.
// Ports:   none (package).
package int_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POLL = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  // Source indices double as fixed polling order (lower index wins).
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  localparam int FLAG_IE0 = 0;
  localparam int FLAG_TF0 = 1;
  localparam int FLAG_IE1 = 2;
  localparam int FLAG_TF1 = 3;
  localparam int FLAG_SER = 4;

  localparam logic [15:0] VEC_IE0 = 16'h0003;
  localparam logic [15:0] VEC_TF0 = 16'h000B;
  localparam logic [15:0] VEC_IE1 = 16'h0013;
  localparam logic [15:0] VEC_TF1 = 16'h001B;
  localparam logic [15:0] VEC_SER = 16'h0023;

  function automatic logic [15:0] vec_of(input logic [2:0] src);
    case (src)
      SRC_IE0: vec_of = VEC_IE0;
      SRC_TF0: vec_of = VEC_TF0;
      SRC_IE1: vec_of = VEC_IE1;
      SRC_TF1: vec_of = VEC_TF1;
      default: vec_of = VEC_SER;
    endcase
  endfunction

  // Timer flags are always cleared by hardware; external flags only when
  // edge-triggered; the serial flag is left for software to clear.
  function automatic logic [4:0] clr_mask(input logic [2:0] src, input logic [1:0] it_mode);
    clr_mask = '0;
    case (src)
      SRC_IE0: clr_mask[FLAG_IE0] = it_mode[0];
      SRC_TF0: clr_mask[FLAG_TF0] = 1'b1;
      SRC_IE1: clr_mask[FLAG_IE1] = it_mode[1];
      SRC_TF1: clr_mask[FLAG_TF1] = 1'b1;
      SRC_SER: clr_mask[FLAG_SER] = 1'b0;
      default: clr_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/int_sched_prio_enc.sv
// rtl/int_sched_prio_enc.sv - combinational winner select among pending sources
// Purpose: picks the lowest-index high-priority pending source, else the
//          lowest-index pending source.
// Ports:   pend[4:0] in, ip[4:0] in (1 = high), valid out, index[2:0] out,
//          level out (1 = winner is high priority).
module int_prio_enc (
  input  logic [4:0] pend,
  input  logic [4:0] ip,
  output logic       valid,
  output logic [2:0] index,
  output logic       level
);

  logic [4:0] hi_pend;
  logic [4:0] sel;

  always_comb begin
    hi_pend = pend & ip;
    valid   = |pend;
    level   = |hi_pend;
    sel     = level ? hi_pend : pend;
    index   = 3'd0;
    // Descending scan so the lowest set index is the last assignment.
    for (int i = 4; i >= 0; i--) begin
      if (sel[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/int_sched.sv
// rtl/int_sched.sv - 8051 interrupt scheduler (sample, arbitrate, request, in-service tracking)
// Purpose: per machine cycle samples enabled interrupt flags, resolves
//          priority/nesting, requests the CPU with a vector, pulses the
//          hardware flag-clear on acceptance and tracks in-service levels.
// Config:  INT_SCHED_PRIORITY_EN defined -> two priority levels from ip;
//          undefined -> ip ignored, everything low priority.
// Ports:   clk, reset (sync, active-low), tick, ie[7:0], ip[7:0], flags[4:0],
//          it_mode[1:0], block, ack, reti -> int_req, vector[15:0], src_id[2:0],
//          clr_flag[4:0], in_svc_hi, in_svc_lo.
module int_sched
  import int_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [7:0]  ie,
  input  logic [7:0]  ip,
  input  logic [4:0]  flags,
  input  logic [1:0]  it_mode,
  input  logic        block,
  input  logic        ack,
  input  logic        reti,
  output logic        int_req,
  output logic [15:0] vector,
  output logic [2:0]  src_id,
  output logic [4:0]  clr_flag,
  output logic        in_svc_hi,
  output logic        in_svc_lo
);

  state_t     state, state_n;
  logic [4:0] pend;
  logic [4:0] sample;
  logic [4:0] ip_eff;
  logic       win_valid;
  logic [2:0] win_idx;
  logic       win_hi;
  logic       win_lvl_q;
  logic       eligible;
  logic       req_keep;
  logic       accept;
  logic       unused_bits;

`ifdef INT_SCHED_PRIORITY_EN
  assign ip_eff      = ip[4:0];
  assign unused_bits = ^{ip[7:5], ie[6:5]};
`else
  assign ip_eff      = 5'b0;
  assign unused_bits = ^{ip, ie[6:5]};
`endif

  assign sample = flags & ie[4:0] & {5{ie[7]}};

  int_prio_enc u_prio_enc (
    .pend  (pend),
    .ip    (ip_eff),
    .valid (win_valid),
    .index (win_idx),
    .level (win_hi)
  );

  // A high-level winner may preempt low service; nothing preempts high.
  assign eligible = win_valid && !block && !in_svc_hi && (win_hi || !in_svc_lo);
  assign req_keep = ie[7] && ie[src_id];
  assign accept   = (state == ST_REQ) && req_keep && ack;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (tick && (sample != 5'b0)) state_n = ST_POLL;
      ST_POLL: state_n = eligible ? ST_REQ : ST_IDLE;
      ST_REQ:  if (!req_keep || ack) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    int_req = (state == ST_REQ);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend      <= '0;
      vector    <= '0;
      src_id    <= '0;
      win_lvl_q <= 1'b0;
      clr_flag  <= '0;
      in_svc_hi <= 1'b0;
      in_svc_lo <= 1'b0;
    end else begin
      clr_flag <= '0;
      if (state == ST_IDLE && tick) pend <= sample;
      if (state == ST_POLL && eligible) begin
        src_id    <= win_idx;
        vector    <= vec_of(win_idx);
        win_lvl_q <= win_hi;
      end
      if (accept) clr_flag <= clr_mask(src_id, it_mode);
      // RETI retires the innermost level first; a same-cycle acceptance
      // then marks the new level, so set overrides clear.
      if (reti) begin
        if (in_svc_hi) in_svc_hi <= 1'b0;
        else           in_svc_lo <= 1'b0;
      end
      if (accept) begin
        if (win_lvl_q) in_svc_hi <= 1'b1;
        else           in_svc_lo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int_sched.sv
// tb/tb_int_sched.sv - self-checking bench for int_sched against a transaction-level model
module tb_int_sched;

  logic        clk = 1'b0;
  logic        reset, tick, block, ack, reti;
  logic [7:0]  ie, ip;
  logic [4:0]  flags;
  logic [1:0]  it_mode;
  logic        int_req, in_svc_hi, in_svc_lo;
  logic [15:0] vector;
  logic [2:0]  src_id;
  logic [4:0]  clr_flag;

  int n_checks = 0;
  int n_errors = 0;

  int_sched dut (
    .clk(clk), .reset(reset), .tick(tick), .ie(ie), .ip(ip), .flags(flags),
    .it_mode(it_mode), .block(block), .ack(ack), .reti(reti),
    .int_req(int_req), .vector(vector), .src_id(src_id), .clr_flag(clr_flag),
    .in_svc_hi(in_svc_hi), .in_svc_lo(in_svc_lo)
  );

  always #5 clk = ~clk;

  // Reference model: a snapshot awaiting arbitration, one outstanding
  // request, and a stack of in-service levels (1 = high).
  bit          have_snap, outstanding;
  logic [4:0]  snap;
  int          m_src, m_lvl;
  int          svc[$];
  logic        e_req;
  logic [15:0] e_vec;
  logic [2:0]  e_src;
  logic [4:0]  e_clr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_level(input int lvl);
    foreach (svc[i]) if (svc[i] == lvl) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit prio_on();
`ifdef INT_SCHED_PRIORITY_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit acc = 0;
    int w = -1, wl = 0;
    if (!reset) begin
      have_snap = 0; outstanding = 0; svc.delete();
      e_req = 0; e_vec = 0; e_src = 0; e_clr = 0;
      return;
    end
    e_clr = 0;
    if (outstanding) begin
      if (!(ie[7] && ie[m_src])) outstanding = 0;
      else if (ack) begin
        outstanding = 0;
        acc = 1;
        if (m_src == 1 || m_src == 3) e_clr[m_src] = 1'b1;
        else if (m_src == 0) e_clr[0] = it_mode[0];
        else if (m_src == 2) e_clr[2] = it_mode[1];
      end
    end else if (have_snap) begin
      have_snap = 0;
      if (prio_on())
        for (int i = 0; i < 5; i++) if (w < 0 && snap[i] && ip[i]) begin w = i; wl = 1; end
      if (w < 0)
        for (int i = 0; i < 5; i++) if (w < 0 && snap[i]) w = i;
      if (!block && !has_level(1) && (wl == 1 || !has_level(0))) begin
        outstanding = 1; m_src = w; m_lvl = wl;
        e_src = 3'(w);
        e_vec = 16'h0003 + 16'(8 * w);
      end
    end else if (tick && ((flags & ie[4:0] & {5{ie[7]}}) != 0)) begin
      have_snap = 1;
      snap = flags & ie[4:0] & {5{ie[7]}};
    end
    if (reti && svc.size() > 0) void'(svc.pop_back());
    if (acc) svc.push_back(m_lvl);
    e_req = outstanding;
  endtask

  task automatic run_cycle();
    model_step();
    @(negedge clk);
    chk("int_req", int_req, e_req);
    chk("vector", vector, e_vec);
    chk("src_id", src_id, e_src);
    chk("clr_flag", clr_flag, e_clr);
    chk("in_svc_hi", in_svc_hi, has_level(1));
    chk("in_svc_lo", in_svc_lo, has_level(0));
  endtask

  task automatic raise(input logic [4:0] f);
    flags = f; tick = 1; run_cycle();
    tick = 0; run_cycle();
  endtask

  task automatic accept_req();
    ack = 1; run_cycle(); ack = 0;
  endtask

  task automatic do_reti();
    reti = 1; run_cycle(); reti = 0;
  endtask

  initial begin
    reset = 0; tick = 0; ie = 0; ip = 0; flags = 0; it_mode = 0;
    block = 0; ack = 0; reti = 0;
    @(negedge clk);
    run_cycle(); run_cycle();
    chk("rst_req", int_req, 0);
    chk("rst_vec", vector, 16'h0000);
    chk("rst_clr", clr_flag, 0);
    reset = 1;

    // Basic edge-triggered IE0 request and acceptance
    ie = 8'h81; it_mode = 2'b01;
    raise(5'b00001);
    chk("t1_req", int_req, 1);
    chk("t1_vec", vector, 16'h0003);
    accept_req();
    chk("t1_clr", clr_flag, 5'b00001);
    chk("t1_lo", in_svc_lo, 1);
    flags = 0;
    do_reti();
    chk("t1_reti_lo", in_svc_lo, 0);

    // IE0 and TF1 pending with TF1 high priority
    ie = 8'h89; ip = 8'h08;
    raise(5'b01001);
`ifdef INT_SCHED_PRIORITY_EN
    chk("t2_vec", vector, 16'h001B);
    chk("t2_src", src_id, 3);
`else
    chk("t2_vec", vector, 16'h0003);
    chk("t2_src", src_id, 0);
`endif
    accept_req();
    do_reti();
    raise(5'b00001);
    chk("t2_ie0_vec", vector, 16'h0003);
    accept_req();
    flags = 0;
    do_reti();

    // High TF0 against low serial in service
    ie = 8'h92; ip = 8'h02;
    raise(5'b10000);
    accept_req();
    chk("t3_lo", in_svc_lo, 1);
    raise(5'b10010);
`ifdef INT_SCHED_PRIORITY_EN
    chk("t3_vec", vector, 16'h000B);
    accept_req();
    chk("t3_hi", in_svc_hi, 1);
    do_reti();
    chk("t3_reti_hi", in_svc_hi, 0);
    chk("t3_reti_lo", in_svc_lo, 1);
`else
    chk("t3_blocked", int_req, 0);
`endif
    flags = 0;
    do_reti();
    chk("t3_lo_clear", in_svc_lo, 0);
    ip = 0;

    // EA cleared while a request is outstanding
    ie = 8'h81;
    raise(5'b00001);
    chk("t4_req", int_req, 1);
    ie = 8'h01; run_cycle();
    chk("t4_withdraw", int_req, 0);
    chk("t4_clr", clr_flag, 0);
    chk("t4_lo", in_svc_lo, 0);
    flags = 0; ie = 8'h81; run_cycle();

    // block during POLL, then IE1 level-triggered acceptance
    ie = 8'h84; it_mode = 2'b00; flags = 5'b00100;
    tick = 1; run_cycle(); tick = 0;
    block = 1; run_cycle(); block = 0;
    chk("t5_blocked", int_req, 0);
    run_cycle();
    raise(5'b00100);
    chk("t5_req", int_req, 1);
    chk("t5_vec", vector, 16'h0013);
    accept_req();
    chk("t5_clr", clr_flag, 0);
    flags = 0;
    do_reti();

    // Reset during REQ
    ie = 8'h81;
    raise(5'b00001);
    chk("t6_req", int_req, 1);
    reset = 0; run_cycle(); reset = 1;
    chk("t6_req0", int_req, 0);
    chk("t6_vec0", vector, 0);
    chk("t6_src0", src_id, 0);
    chk("t6_lo0", in_svc_lo, 0);
    chk("t6_hi0", in_svc_hi, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 299) != 0);
      tick    = ($urandom_range(0, 2) == 0);
      ie      = {($urandom_range(0, 9) != 0), 2'($urandom), 5'($urandom)};
      ip      = 8'($urandom);
      flags   = 5'($urandom) & 5'($urandom);
      it_mode = 2'($urandom);
      block   = ($urandom_range(0, 4) == 0);
      ack     = (e_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 19) == 0);
      reti    = (svc.size() > 0 && $urandom_range(0, 5) == 0) || ($urandom_range(0, 29) == 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
